// File: rtl/sched_pkg.sv
// sched_pkg: shared mode encodings, scheduler states and region base addresses
package sched_pkg;
    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_CTX  = 2'd1;
    localparam logic [1:0] MODE_SO   = 2'd2;
    localparam logic [1:0] MODE_USER = 2'd3;

    localparam int CTX_BASE  = 0;
    localparam int SO_BASE   = 200;
    localparam int PROG_BASE = 400;

    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        SELECT,
        RUN,
        SAVE,
        WAIT_ANY
    } state_t;

    // SELECT has no region of its own; callers keep the previous owner there
    function automatic logic [1:0] mode_of(state_t s);
        return s == BOOT ? MODE_SO : s == RUN ? MODE_USER : s == SAVE ? MODE_CTX : MODE_IDLE;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first set mask bit after last, wrapping, with last itself checked last
module rr_picker #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] index
);
    logic [IW-1:0] c;

    // scan farthest offset first so the nearest hit overwrites
    always_comb begin
        found = 1'b0;
        index = last;
        c     = '0;
        for (int k = N; k > 0; k--) begin
            c = IW'((int'(last) + k) % N);
            if (mask[c]) begin
                found = 1'b1;
                index = c;
            end
        end
    end
endmodule

// File: rtl/quantum_scheduler.sv
// quantum_scheduler: time-sliced round-robin owner of the instruction address space
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_PROCS  = 8,
    parameter int SLOT_SIZE  = 200,
    parameter int QUANTUM    = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [NUM_PROCS-1:0]  proc_ready,
    input  logic                  proc_done,
    input  logic                  so_done,
    input  logic                  switch_done,
    output logic [1:0]            mode,
    output logic [2:0]            cur_proc,
    output logic [ADDR_WIDTH-1:0] region_base,
    output logic                  timer_irq
);
    localparam int CW = $clog2(QUANTUM + 1);

    state_t                state_q, state_d;
    logic [2:0]            cur_q, cur_d, pick;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_PROCS-1:0]  done_q, done_d, eligible;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  irq_q, irq_d, found;

    assign eligible = proc_ready & ~done_q;

    rr_picker #(.N(NUM_PROCS), .IW(3)) u_picker (
        .mask (eligible),
        .last (cur_q),
        .found(found),
        .index(pick)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        irq_d   = 1'b0;
        case (state_q)
            IDLE:     state_d = start ? BOOT : IDLE;
            BOOT:     state_d = so_done ? SELECT : BOOT;
            SELECT: begin
                cnt_d   = '0;
                cur_d   = found ? pick : cur_q;
                state_d = found ? RUN : WAIT_ANY;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // a halt on the last slice cycle is still a halt: mask it, one SAVE
                if (proc_done) begin
                    done_d[cur_q] = 1'b1;
                    state_d       = SAVE;
                    irq_d         = 1'b1;
                end else if (cnt_q == CW'(QUANTUM - 1)) begin
                    state_d = SAVE;
                    irq_d   = 1'b1;
                end
            end
            SAVE:     state_d = switch_done ? SELECT : SAVE;
            WAIT_ANY: state_d = |eligible ? SELECT : WAIT_ANY;
            default:  state_d = IDLE;
        endcase
        mode_d = state_d == SELECT ? mode_q : mode_of(state_d);
        base_d = state_d == SELECT ? base_q :
                 state_d == BOOT   ? ADDR_WIDTH'(SO_BASE) :
                 state_d == RUN    ? ADDR_WIDTH'(PROG_BASE) + ADDR_WIDTH'(cur_d) * ADDR_WIDTH'(SLOT_SIZE) :
                                     ADDR_WIDTH'(CTX_BASE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cur_q   <= 3'(NUM_PROCS - 1);
            cnt_q   <= '0;
            done_q  <= '0;
            mode_q  <= MODE_IDLE;
            base_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            irq_q   <= irq_d;
        end
    end

    assign mode        = mode_q;
    assign cur_proc    = cur_q;
    assign region_base = base_q;
    assign timer_irq   = irq_q;
endmodule

// File: tb/tb_quantum_scheduler.sv
// tb_quantum_scheduler: directed scenarios plus random traffic against a phase-level model
module tb_quantum_scheduler;
    localparam int NP = 8;
    localparam int SS = 200;
    localparam int Q  = 64;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [NP-1:0] proc_ready = '0;
    logic          proc_done = 1'b0;
    logic          so_done = 1'b0;
    logic          switch_done = 1'b0;
    logic [1:0]    mode;
    logic [2:0]    cur_proc;
    logic [AW-1:0] region_base;
    logic          timer_irq;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    quantum_scheduler #(
        .NUM_PROCS(NP), .SLOT_SIZE(SS), .QUANTUM(Q), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .proc_ready(proc_ready),
        .proc_done(proc_done), .so_done(so_done), .switch_done(switch_done),
        .mode(mode), .cur_proc(cur_proc), .region_base(region_base), .timer_irq(timer_irq)
    );

    typedef enum {M_IDLE, M_BOOT, M_SEL, M_RUN, M_SAVE, M_WAIT} phase_t;
    phase_t        ph;
    int            m_cur, left, m_mode, m_base;
    logic [NP-1:0] m_done;
    bit            m_irq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_pick(input logic [NP-1:0] elig, input int last);
        for (int k = 1; k <= NP; k++)
            if (elig[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    task automatic model_reset();
        ph = M_IDLE; m_cur = NP - 1; left = 0; m_done = '0;
        m_mode = 0; m_base = 0; m_irq = 0;
    endtask

    task automatic model_step();
        logic [NP-1:0] elig;
        int p;
        elig  = proc_ready & ~m_done;
        m_irq = 0;
        case (ph)
            M_IDLE: if (start) ph = M_BOOT;
            M_BOOT: if (so_done) ph = M_SEL;
            M_SEL: begin
                p = next_pick(elig, m_cur);
                if (p < 0) ph = M_WAIT;
                else begin m_cur = p; left = Q; ph = M_RUN; end
            end
            M_RUN: begin
                left--;
                if (proc_done) begin m_done[m_cur] = 1'b1; ph = M_SAVE; m_irq = 1; end
                else if (left == 0) begin ph = M_SAVE; m_irq = 1; end
            end
            M_SAVE: if (switch_done) ph = M_SEL;
            M_WAIT: if (elig != 0) ph = M_SEL;
            default: ph = M_IDLE;
        endcase
        if (ph != M_SEL) begin
            m_mode = ph == M_BOOT ? 2 : ph == M_RUN ? 3 : ph == M_SAVE ? 1 : 0;
            m_base = ph == M_BOOT ? 200 : ph == M_RUN ? 400 + m_cur * SS : 0;
        end
    endtask

    task automatic compare();
        check("mode", mode, m_mode);
        check("cur_proc", cur_proc, m_cur);
        check("region_base", region_base, m_base);
        check("timer_irq", timer_irq, m_irq);
    endtask

    task automatic tick(input bit st, input logic [NP-1:0] rdy, input bit pd, input bit sd, input bit swd);
        start = st; proc_ready = rdy; proc_done = pd; so_done = sd; switch_done = swd;
        @(posedge clock);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle_ticks(input int n, input logic [NP-1:0] rdy);
        for (int i = 0; i < n; i++) tick(0, rdy, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_mode", mode, 0);
        check("rst_cur", cur_proc, NP - 1);
        check("rst_base", region_base, 0);
        check("rst_irq", timer_irq, 0);
        @(posedge clock);
        #1;
        check("rst_hold_irq", timer_irq, 0);
        check("rst_hold_mode", mode, 0);
        @(negedge clock);
        reset_n = 1'b1;
        proc_done = 0; so_done = 0; switch_done = 0; start = 0;
    endtask

    task automatic boot_to_run(input logic [NP-1:0] rdy);
        tick(1, rdy, 0, 0, 0);
        tick(0, rdy, 0, 1, 0);
        tick(0, rdy, 0, 0, 0);
    endtask

    initial begin
        logic [NP-1:0] rdy;
        #2;
        do_reset();

        // boot with a single loaded slot, so_done on the fifth cycle
        for (int i = 0; i < 4; i++) tick(1, 8'h01, 0, 0, 0);
        check("boot_mode", mode, 2);
        check("boot_base", region_base, 200);
        tick(0, 8'h01, 0, 1, 0);
        tick(0, 8'h01, 0, 0, 0);
        check("boot_run_mode", mode, 3);
        check("boot_run_base", region_base, 400);
        check("boot_run_cur", cur_proc, 0);

        // full quantum, spurious pulses, then handoff 1 -> 2
        do_reset();
        boot_to_run(8'h06);
        check("q_base1", region_base, 600);
        for (int i = 0; i < Q - 1; i++) begin
            tick(0, 8'h06, 0, 0, i == 10);
            check("q_still_run", mode, 3);
        end
        tick(0, 8'h06, 0, 0, 0);
        check("q_irq", timer_irq, 1);
        check("q_save_mode", mode, 1);
        check("q_save_base", region_base, 0);
        tick(0, 8'h06, 1, 0, 0);
        check("q_irq_once", timer_irq, 0);
        check("q_spurious_done", mode, 1);
        tick(0, 8'h06, 0, 0, 1);
        tick(0, 8'h06, 0, 0, 0);
        check("q_cur2", cur_proc, 2);
        check("q_base2", region_base, 800);

        // wrap from slot 7 back to slot 0
        do_reset();
        boot_to_run(8'h81);
        idle_ticks(Q, 8'h81);
        tick(0, 8'h81, 0, 0, 1);
        tick(0, 8'h81, 0, 0, 0);
        check("wrap_cur7", cur_proc, 7);
        idle_ticks(Q, 8'h81);
        tick(0, 8'h81, 0, 0, 1);
        tick(0, 8'h81, 0, 0, 0);
        check("wrap_cur0", cur_proc, 0);
        check("wrap_base0", region_base, 400);

        // halt colliding with quantum expiry, then drain to WAIT_ANY
        do_reset();
        boot_to_run(8'h03);
        idle_ticks(Q - 1, 8'h03);
        tick(0, 8'h03, 1, 0, 0);
        check("col_irq", timer_irq, 1);
        tick(0, 8'h03, 0, 0, 0);
        check("col_irq_once", timer_irq, 0);
        tick(0, 8'h03, 0, 0, 1);
        tick(0, 8'h03, 0, 0, 0);
        check("col_next", cur_proc, 1);
        tick(0, 8'h03, 1, 0, 0);
        tick(0, 8'h03, 0, 0, 1);
        tick(0, 8'h03, 0, 0, 0);
        check("col_wait_mode", mode, 0);
        idle_ticks(3, 8'h03);
        check("col_wait_stay", mode, 0);
        tick(0, 8'h07, 0, 0, 0);
        tick(0, 8'h07, 0, 0, 0);
        check("col_new_cur", cur_proc, 2);
        check("col_new_base", region_base, 800);

        // reset mid-RUN, then start is required again
        do_reset();
        boot_to_run(8'h01);
        idle_ticks(30, 8'h01);
        do_reset();
        idle_ticks(5, 8'h01);
        check("rst_idle_stay", mode, 0);
        boot_to_run(8'h01);
        check("rst_restart", mode, 3);

        // random traffic
        do_reset();
        rdy = 8'($urandom);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) rdy = 8'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset();
            tick($urandom_range(0, 3) == 0, rdy, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
